// File: rtl/bin2bcd_stream.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3) with valid/ready on both sides,
// optional two's-complement input, significant-digit count and overflow flag.
module bin2bcd_stream #(
  parameter int BW     = 16,
  parameter int DIGITS = BW*28/93+1,
  parameter int SIGNED = 0,
  parameter int NDW    = $clog2(DIGITS+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BW-1:0]       bIn,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIGITS*4-1:0] bcd,
  output logic                sign_out,
  output logic [NDW-1:0]      ndigits,
  output logic                overflow
);

  localparam int AW = DIGITS*4;
  localparam int CW = $clog2(BW+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  shreg;
  logic [AW-1:0]  acc;
  logic           ovf;
  logic           neg_r;
  logic [CW-1:0]  count;

  logic [AW-1:0]  acc_corr, acc_nxt;
  logic           ovf_nxt;
  logic [NDW-1:0] nd_nxt;
  logic [BW-1:0]  mag;
  logic           neg;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)               state_nxt = SHIFT;
      SHIFT:   if (count == CW'(1))        state_nxt = DONE;
      DONE:    if (out_ready)              state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    neg = (SIGNED != 0) && bIn[BW-1];
    // Negating the most negative value wraps to 2^(BW-1), which is the correct magnitude.
    mag = neg ? (~bIn + BW'(1)) : bIn;
    acc_corr = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      acc_corr[4*i +: 4] = (acc[4*i +: 4] > 4'd4) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    acc_nxt = {acc_corr[AW-2:0], shreg[BW-1]};
    // A set bit leaving the top digit means the true value has more digits than we keep.
    ovf_nxt = ovf | acc_corr[AW-1];
    nd_nxt  = NDW'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_nxt[4*i +: 4] != 4'd0) nd_nxt = NDW'(i+1);
    end
    if (ovf_nxt) nd_nxt = NDW'(DIGITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
      bcd      <= '0;
      sign_out <= 1'b0;
      ndigits  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= mag;
            neg_r <= neg;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= CW'(BW);
          end
        end
        SHIFT: begin
          shreg <= {shreg[BW-2:0], 1'b0};
          acc   <= acc_nxt;
          ovf   <= ovf_nxt;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd      <= acc_nxt;
            sign_out <= neg_r;
            overflow <= ovf_nxt;
            ndigits  <= nd_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
